// File: rtl/alu_pkg.sv
// Shared definitions for the ALU response checker.
//   - OP_* : ALU_Sel opcode encodings.
//   - EXP_W / SB_W : widths of the {carry, out} result and of a queued
//     expectation entry {sel, carry, out}.
//   - alu_ref() : golden model of the 8-bit ALU. It returns {carry, out}.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOR = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_SHL = 3'b111;

  localparam int EXP_W = 9;
  localparam int SB_W  = 3 + EXP_W;

  function automatic logic [EXP_W-1:0] alu_ref(input logic [7:0] a,
                                               input logic [7:0] b,
                                               input logic [2:0] sel);
    logic [EXP_W-1:0] r;
    r = '0;
    case (sel)
      OP_ADD:  r = {1'b0, a} + {1'b0, b};
      // A 9-bit subtract wraps negative results, so bit 8 is the borrow.
      OP_SUB:  r = {1'b0, a} - {1'b0, b};
      OP_AND:  r = {1'b0, a & b};
      OP_OR:   r = {1'b0, a | b};
      OP_XOR:  r = {1'b0, a ^ b};
      OP_NOR:  r = {1'b0, ~(a | b)};
      OP_SLT:  r = {8'h00, (a < b)};
      OP_SHL:  r = {a[7], a[6:0], 1'b0};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_sb_fifo.sv
// In-order queue that holds the expectations for the checker.
// Ports:
//   clk, rst        : clock and asynchronous active-high reset.
//   push, din       : this cycle writes din. The write is ignored when the queue is full.
//   pop, dout       : this cycle removes the head. dout always shows the head entry.
//                     A pop is ignored when the queue is empty.
//   full, empty     : queue state, derived from count.
//   count           : number of entries stored (0..DEPTH).
// DEPTH must be a power of 2. The pointers then wrap naturally modulo DEPTH.
module alu_sb_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = SB_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    full     = (count_q == CW'(DEPTH));
    empty    = (count_q == '0);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    dout     = mem_q[rd_ptr_q];
    count    = count_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // The storage needs no reset. An entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/alu_scoreboard.sv
// Response checker for the 8-bit ALU.
// Handshake: a request is accepted on a rising edge where req_valid && req_ready.
// req_ready is registered and is high whenever the queue is not full.
// A response (rsp_valid) has no back-pressure. It pops the oldest expectation
// and compares against it. A response that arrives with nothing outstanding
// is flagged as unexpected.
// Ports:
//   clk, rst                       : clock and asynchronous active-high reset.
//   req_valid/req_ready/req_a/b/sel: operation issue side.
//   rsp_valid/rsp_out/rsp_carry    : DUT result side.
//   pass_count, fail_count         : saturating match/mismatch counters.
//   err, unexpected_rsp            : sticky error flags.
//   fail_sel/fail_exp/fail_got     : snapshot of the first mismatch.
//   pending                        : number of outstanding expectations.
module alu_scoreboard
  import alu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [7:0]             req_a,
  input  logic [7:0]             req_b,
  input  logic [2:0]             req_sel,
  input  logic                   rsp_valid,
  input  logic [7:0]             rsp_out,
  input  logic                   rsp_carry,
  output logic [CNT_W-1:0]       pass_count,
  output logic [CNT_W-1:0]       fail_count,
  output logic                   err,
  output logic                   unexpected_rsp,
  output logic [2:0]             fail_sel,
  output logic [EXP_W-1:0]       fail_exp,
  output logic [EXP_W-1:0]       fail_got,
  output logic [$clog2(DEPTH):0] pending
);

  localparam int PW = $clog2(DEPTH) + 1;

  logic [SB_W-1:0]  head;
  logic             fifo_full, fifo_empty;
  logic [PW-1:0]    fifo_count, pending_next;
  logic             do_push, do_pop, unexp_hit, mismatch;
  logic [EXP_W-1:0] got;

  logic             req_ready_q, req_ready_d;
  logic [CNT_W-1:0] pass_q, pass_d, fail_q, fail_d;
  logic             err_q, err_d, unexp_q, unexp_d;
  logic [2:0]       fail_sel_q, fail_sel_d;
  logic [EXP_W-1:0] fail_exp_q, fail_exp_d, fail_got_q, fail_got_d;

  alu_sb_fifo #(.DEPTH(DEPTH), .WIDTH(SB_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (do_push),
    .din   ({req_sel, alu_ref(req_a, req_b, req_sel)}),
    .pop   (do_pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    do_push   = req_valid && req_ready_q && !fifo_full;
    do_pop    = rsp_valid && !fifo_empty;
    unexp_hit = rsp_valid && fifo_empty;
    got       = {rsp_carry, rsp_out};
    mismatch  = (got != head[EXP_W-1:0]);

    // req_ready is registered. It therefore looks at the occupancy after this edge.
    pending_next = fifo_count + PW'(do_push) - PW'(do_pop);
    req_ready_d  = (pending_next != PW'(DEPTH));

    pass_d = pass_q;
    if (do_pop && !mismatch && (pass_q != '1)) pass_d = pass_q + CNT_W'(1);
    fail_d = fail_q;
    if (do_pop && mismatch && (fail_q != '1)) fail_d = fail_q + CNT_W'(1);

    err_d   = err_q | (do_pop && mismatch) | unexp_hit;
    unexp_d = unexp_q | unexp_hit;

    // Only the first mismatch is kept. Later mismatches leave the snapshot alone.
    fail_sel_d = fail_sel_q;
    fail_exp_d = fail_exp_q;
    fail_got_d = fail_got_q;
    if (do_pop && mismatch && (fail_q == '0)) begin
      fail_sel_d = head[SB_W-1:EXP_W];
      fail_exp_d = head[EXP_W-1:0];
      fail_got_d = got;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready_q <= 1'b0;
      pass_q      <= '0;
      fail_q      <= '0;
      err_q       <= 1'b0;
      unexp_q     <= 1'b0;
      fail_sel_q  <= '0;
      fail_exp_q  <= '0;
      fail_got_q  <= '0;
    end else begin
      req_ready_q <= req_ready_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      err_q       <= err_d;
      unexp_q     <= unexp_d;
      fail_sel_q  <= fail_sel_d;
      fail_exp_q  <= fail_exp_d;
      fail_got_q  <= fail_got_d;
    end
  end

  always_comb begin
    req_ready      = req_ready_q;
    pass_count     = pass_q;
    fail_count     = fail_q;
    err            = err_q;
    unexpected_rsp = unexp_q;
    fail_sel       = fail_sel_q;
    fail_exp       = fail_exp_q;
    fail_got       = fail_got_q;
    pending        = fifo_count;
  end

endmodule
